muldiv_unit: RTL and testbench

Parametrised multi-cycle RV64M multiply/divide unit sitting beside the single-cycle ALU in the execute stage. It takes one operation at a time over a valid/ready handshake and computes MUL/MULH*/DIV*/REM* and their W forms with RISC-V-exact corner-case results. Results are held until the writeback side accepts them. A flush from the pipeline cancels any in-flight operation.

---
 rtl/muldiv_pkg.sv | 54 +++++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_unit.sv | 219 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: operation codes, FSM states and op-decoding helpers shared by
// the muldiv_unit datapath and control.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_FIXUP,
        ST_DONE
    } muldiv_state_e;

    function automatic logic is_w(input muldiv_op_e op);
        return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                          OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_mul_high(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    // MULW only keeps the low 32 product bits, which do not depend on signedness.
    function automatic logic is_signed_a(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration of the magnitude datapath -- a radix-2 shift-add
// multiply step or a restoring divide step on the {hi, lo} register pair.
module muldiv_step #(
    parameter int XLEN = 64
) (
    input  logic            div_mode,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            fits;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        shifted = {hi, lo[XLEN-1]};
        fits    = shifted >= {1'b0, operand};
        // The partial remainder after subtraction is below the divisor, so it fits XLEN bits.
        diff    = shifted[XLEN-1:0] - operand;
        if (div_mode) begin
            hi_next = fits ? diff : shifted[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], fits};
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV64M multiply/divide with valid/ready handshake and flush.
// Build option MULDIV_FAST_MUL_EN: multiplies complete in one cycle via a combinational product.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_rd,
    input  logic [31:0]     in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic [31:0]     out_pc,
    output logic            busy
);

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [6:0]      CNT_FULL = 7'(XLEN - 1);
    localparam logic [6:0]      CNT_W    = 7'd31;
    localparam int              W_SHIFT  = XLEN - 32;

    muldiv_state_e   state_q, state_d;
    muldiv_op_e      op_q, op_d, in_op_e;
    logic [6:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic            neg_q, neg_d, w_q, w_d;
    logic            out_valid_q, out_valid_d, busy_q, busy_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic [31:0]     out_pc_q, out_pc_d;

    logic            accept, w_mode, signed_a, signed_b, sign_a, sign_b, div_zero, div_ovf;
    logic [XLEN-1:0] a_eff, b_eff, mag_a, mag_b, special_val, div_val, div_val_s;
    logic [XLEN-1:0] hi_step, lo_step;
    logic [2*XLEN-1:0] prod_norm;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
`endif

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sext);
        logic [XLEN-1:0] r;
        r       = {XLEN{sext & v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mul_select(input muldiv_op_e op, input logic w,
                                                   input logic neg, input logic [2*XLEN-1:0] prod);
        logic [2*XLEN-1:0] p;
        p = neg ? -prod : prod;
        if (w)                return ext32(p[31:0], 1'b1);
        else if (is_mul_high(op)) return p[2*XLEN-1:XLEN];
        return p[XLEN-1:0];
    endfunction

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_mode (is_div(op_q)),
        .hi       (hi_q),
        .lo       (lo_q),
        .operand  (opnd_q),
        .hi_next  (hi_step),
        .lo_next  (lo_step)
    );

    assign in_op_e   = muldiv_op_e'(in_op);
    assign in_ready  = reset && (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign out_pc    = out_pc_q;
    assign busy      = busy_q;

    // Operand decode: W ops work on the low words, extended per the op's signedness.
    always_comb begin
        w_mode   = (XLEN == 64) && is_w(in_op_e);
        signed_a = is_signed_a(in_op_e);
        signed_b = is_signed_b(in_op_e);
        a_eff    = w_mode ? ext32(in_a[31:0], signed_a) : in_a;
        b_eff    = w_mode ? ext32(in_b[31:0], signed_b) : in_b;
        sign_a   = signed_a && a_eff[XLEN-1];
        sign_b   = signed_b && b_eff[XLEN-1];
        mag_a    = sign_a ? -a_eff : a_eff;
        mag_b    = sign_b ? -b_eff : b_eff;
        div_zero = (b_eff == '0);
        div_ovf  = signed_a && (w_mode ? (in_a[31:0] == 32'h8000_0000 && in_b[31:0] == 32'hFFFF_FFFF)
                                       : (in_a == MIN_NEG && in_b == '1));
        if (div_zero) special_val = is_rem(in_op_e) ? a_eff : '1;
        else          special_val = is_rem(in_op_e) ? '0 : a_eff;
        if (w_mode)   special_val = ext32(special_val[31:0], 1'b1);
`ifdef MULDIV_FAST_MUL_EN
        fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif
    end

    // Result fixup: a W multiply leaves its 64-bit product shifted up by W_SHIFT.
    always_comb begin
        prod_norm = w_q ? ({hi_q, lo_q} >> W_SHIFT) : {hi_q, lo_q};
        div_val   = is_rem(op_q) ? hi_q : lo_q;
        div_val_s = neg_q ? -div_val : div_val;
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through this block infers a latch.
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        neg_d       = neg_q;
        w_d         = w_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_pc_d    = out_pc_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d     = in_op_e;
                    w_d      = w_mode;
                    neg_d    = is_rem(in_op_e) ? sign_a : (sign_a ^ sign_b);
                    out_rd_d = in_rd;
                    out_pc_d = in_pc;
                    hi_d     = '0;
                    cnt_d    = w_mode ? CNT_W : CNT_FULL;
                    state_d  = ST_ITER;
                    if (is_div(in_op_e)) begin
                        lo_d   = w_mode ? (mag_a << W_SHIFT) : mag_a;
                        opnd_d = mag_b;
                        if (div_zero || div_ovf) begin
                            state_d     = ST_DONE;
                            out_valid_d = 1'b1;
                            out_data_d  = special_val;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = mul_select(in_op_e, w_mode, sign_a ^ sign_b, fast_prod);
`else
                        lo_d   = mag_b;
                        opnd_d = mag_a;
`endif
                    end
                end
            end
            ST_ITER: begin
                hi_d = hi_step;
                lo_d = lo_step;
                if (cnt_q == 7'd0) state_d = ST_FIXUP;
                else               cnt_d   = cnt_q - 7'd1;
            end
            ST_FIXUP: begin
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
                if (is_div(op_q)) out_data_d = w_q ? ext32(div_val_s[31:0], 1'b1) : div_val_s;
                else              out_data_d = mul_select(op_q, w_q, neg_q, prod_norm);
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: only non-blocking assignments here, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            neg_q       <= 1'b0;
            w_q         <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_pc_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            neg_q       <= neg_d;
            w_q         <= w_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_pc_q    <= out_pc_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table, handshake/flush/reset sequences and
// randomized ops checked against an arithmetic reference model (XLEN=64).
module tb_muldiv_unit;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic [31:0] out_pc;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rd     (in_rd),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_pc    (out_pc),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic bit tb_is_div(input logic [3:0] op);
        return (op >= 4'd4 && op <= 4'd7) || (op >= 4'd9 && op <= 4'd12);
    endfunction

    // Reference arithmetic straight from the RISC-V M-extension definitions.
    function automatic logic [63:0] ref_data(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       p;
        logic signed [63:0] sa, sb, q, r;
        logic signed [31:0] sa32, sb32, q32, r32s;
        logic [31:0]        a32, b32, r32;
        logic [63:0]        res;
        sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
        res = '0; r32 = '0;
        case (op)
            4'd0: res = a * b;
            4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; res = p[127:64]; end
            4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       res = p[127:64]; end
            4'd3: begin p = {64'd0, a} * {64'd0, b};             res = p[127:64]; end
            4'd4: begin
                if (b == 0) res = '1;
                else if (a == MIN64 && b == '1) res = a;
                else begin q = sa / sb; res = q; end
            end
            4'd5: res = (b == 0) ? '1 : a / b;
            4'd6: begin
                if (b == 0) res = a;
                else if (a == MIN64 && b == '1) res = '0;
                else begin r = sa % sb; res = r; end
            end
            4'd7: res = (b == 0) ? a : a % b;
            4'd8: r32 = a32 * b32;
            4'd9: begin
                if (b32 == 0) r32 = '1;
                else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
                else begin q32 = sa32 / sb32; r32 = q32; end
            end
            4'd10: r32 = (b32 == 0) ? '1 : a32 / b32;
            4'd11: begin
                if (b32 == 0) r32 = a32;
                else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
                else begin r32s = sa32 % sb32; r32 = r32s; end
            end
            4'd12: r32 = (b32 == 0) ? a32 : a32 % b32;
            default: res = '0;
        endcase
        if (op >= 4'd8) res = {{32{r32[31]}}, r32};
        return res;
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        bit w, sgn, zero, ovf;
        w   = op >= 4'd8;
        sgn = op inside {4'd4, 4'd6, 4'd9, 4'd11};
        if (tb_is_div(op)) begin
            zero = w ? (b[31:0] == 0) : (b == 0);
            ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                             : (a == MIN64 && b == '1));
            if (zero || ovf) return 1;
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            return 1;
`endif
        end
        return w ? 34 : 66;
    endfunction

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return MIN64;
            3: return 64'($urandom_range(0, 100));
            4: return 64'hFFFF_FFFF_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Offers one op at a negedge and returns just after the accepting edge.
    task automatic start_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] rd, input logic [31:0] pc);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd; in_pc = pc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // k counts sampled cycles after the accept edge; k=1 is cycle t+1.
    task automatic wait_valid(input string name, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check({name, "_busy"}, 64'(busy), 64'd1);
                check({name, "_in_ready_low"}, 64'(in_ready), 64'd0);
            end
        end while (!out_valid && k < 200);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat, input string name);
        int k;
        logic [4:0]  rd;
        logic [31:0] pc;
        rd = 5'($urandom);
        pc = $urandom;
        @(negedge clk);
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        start_op(op, a, b, rd, pc);
        wait_valid(name, k);
        check({name, "_latency"}, 64'(k), 64'(exp_lat));
        check({name, "_data"}, out_data, exp);
        check({name, "_rd"}, 64'(out_rd), 64'(rd));
        check({name, "_pc"}, 64'(out_pc), 64'(pc));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({name, "_drained"}, 64'(out_valid), 64'd0);
        check({name, "_ready_again"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int seen;
        logic [3:0]  op;
        logic [63:0] a, b;

        vecs.push_back('{4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66, "mulh_m1_m1"});
        vecs.push_back('{4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 66, "mul_m1_m1"});
        vecs.push_back('{4'd4,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66, "div_m20_3"});
        vecs.push_back('{4'd6,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66, "rem_m20_3"});
        vecs.push_back('{4'd5,  64'd20, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu_by_zero"});
        vecs.push_back('{4'd4,  MIN64, 64'hFFFF_FFFF_FFFF_FFFF, MIN64, 1, "div_overflow"});
        vecs.push_back('{4'd6,  MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, "rem_overflow"});
        vecs.push_back('{4'd9,  64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "divw_overflow"});
        vecs.push_back('{4'd8,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, "mulw_wrap"});
        vecs.push_back('{4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, "mulhsu_m1_2"});
        vecs.push_back('{4'd11, 64'h1_8000_0005, 64'h7_0000_0000, 64'hFFFF_FFFF_8000_0005, 1, "remw_by_zero"});
        vecs.push_back('{4'd10, 64'hFFFF_FFFF, 64'd2, 64'h7FFF_FFFF, 34, "divuw_big"});
        vecs.push_back('{4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66, "mulhu_max"});

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("reset_out_rd", 64'(out_rd), 64'd0);
        check("reset_out_pc", 64'(out_pc), 64'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            int lat;
            lat = vecs[i].lat;
`ifdef MULDIV_FAST_MUL_EN
            if (!tb_is_div(vecs[i].op)) lat = 1;
`endif
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, lat, vecs[i].name);
        end

        // Back-pressure: result held stable for 5 cycles, then drained.
        start_op(4'd4, 64'd100, 64'd7, 5'd17, 32'hCAFE_0010);
        wait_valid("stall", k);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", out_data, 64'd14);
            check("stall_rd", 64'(out_rd), 64'd17);
            check("stall_pc", 64'(out_pc), 64'hCAFE_0010);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_release_in_ready", 64'(in_ready), 64'd1);
        check("stall_release_valid", 64'(out_valid), 64'd0);

        // Flush at t+10 of a DIV
        start_op(4'd4, 64'd1000, 64'd7, 5'd3, 32'h100);
        for (int i = 0; i < 10; i++) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_result", 64'(seen), 64'd0);

        // Flush coincident with the accept discards the offered op
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'd5; in_a = 64'd9; in_b = 64'd0; flush = 1'b1;
        @(posedge clk);
        #1 begin in_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check("flush_accept_busy", 64'(busy), 64'd0);
        check("flush_accept_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_accept_no_result", 64'(seen), 64'd0);

        // Reset low mid-ITER
        start_op(4'd4, 64'd12345, 64'd11, 5'd9, 32'h1234);
        for (int i = 0; i < 5; i++) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_out_data", out_data, 64'd0);
        check("midreset_out_rd", 64'(out_rd), 64'd0);
        check("midreset_out_pc", 64'(out_pc), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_release_in_ready", 64'(in_ready), 64'd1);

        // Randomized ops against the reference model
        for (int n = 0; n < 120; n++) begin
            op = 4'($urandom_range(0, 12));
            a  = rnd_operand();
            b  = rnd_operand();
            run_op(op, a, b, ref_data(op, a, b), ref_lat(op, a, b), $sformatf("rnd%0d_op%0d", n, op));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
